load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ALIGN_CHECK, default 1, meaning 1 = misaligned H/W accesses fault, 0 = address low bits ignored (forced aligned).
REQ-002 SHALL have one clock `clk` and one reset `rst_n`; reset is asynchronous, active-low.
REQ-003 Ports, in this order:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  async active-low reset
- req_valid  in  1  pipeline load/store request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result, extended; 0 for stores and faults
- rsp_misaligned  out  1  misaligned-access fault
- rsp_illegal  out  1  illegal funct3 fault (011, 110, 111; 100/101 with req_we=1)
- mem_address  out  32  word-aligned byte address {addr[31:2],2'b00} to data memory
- mem_write_data  out  32  full merged word to data memory
- mem_write  out  1  data memory write enable, write on rising edge
- mem_read  out  1  data memory read enable
- mem_read_data  in  32  data memory read word, valid in the same cycle as mem_read

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, STORE_RD, STORE_WR, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready at rising edge; request fields captured into registers then.
REQ-006 Fault check at capture: H needs addr[0]=0, W needs addr[1:0]=00 (ALIGN_CHECK=1 only); fault -> IDLE to RESP directly, no mem_read/mem_write asserted.
REQ-007 Transitions: legal load IDLE->LOAD->RESP; store B/H IDLE->STORE_RD->STORE_WR->RESP; store W IDLE->STORE_WR->RESP; RESP->IDLE on rsp_ready.
REQ-008 LOAD and STORE_RD SHALL assert mem_read=1 for exactly one cycle and capture mem_read_data at the ending edge.
REQ-009 STORE_WR SHALL assert mem_write=1 for exactly one cycle; mem_read=0 there.
REQ-010 mem_read and mem_write SHALL never be 1 simultaneously and SHALL be 0 in IDLE and RESP.
REQ-011 Store merge: B replaces byte lane addr[1:0] with wdata[7:0]; H replaces lane addr[1] halfword with wdata[15:0]; W writes wdata unmodified; other bytes from captured old word.
REQ-012 Load extract: lane selected by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes word.
REQ-013 Latency from handshake edge to rsp_valid: load 2 cycles, store W 2, store B/H 3, fault 1.
REQ-014 In RESP, rsp_valid=1 and rsp_rdata, rsp_misaligned, rsp_illegal SHALL stay stable until rsp_ready=1; no new request accepted during RESP.
REQ-015 rsp_misaligned and rsp_illegal SHALL be mutually exclusive; illegal funct3 takes priority.
REQ-016 mem_address and mem_write_data SHALL hold last driven values outside LOAD/STORE_RD/STORE_WR.

Reset
REQ-017 rst_n=0 SHALL immediately force state IDLE, mem_read=0, mem_write=0, rsp_valid=0, rsp_misaligned=0, rsp_illegal=0, rsp_rdata=0, mem_address=0, mem_write_data=0; req_ready=1 from first edge after release.
REQ-018 Reset mid-operation SHALL abort the access; a store in STORE_WR with rst_n asserted before the edge SHALL NOT modify memory; no response produced.

Verification
REQ-019 Data memory word i preloaded 2*i; LW addr 0x8 -> rsp_valid 2 cycles after handshake, rsp_rdata=0x00000004, mem_read high exactly 1 cycle.
REQ-020 SB addr 0x5, wdata 0x000000AB -> word 1 becomes 0x0000AB02; one mem_read cycle then one mem_write cycle; rsp_valid at cycle 3.
REQ-021 After REQ-020: LB addr 0x5 -> 0xFFFFFFAB; LBU addr 0x5 -> 0x000000AB; LHU addr 0x4 -> 0x0000AB02.
REQ-022 LH addr 0x3 -> rsp_misaligned=1, rsp_rdata=0, rsp_valid 1 cycle after handshake, no mem_read/mem_write; funct3=011 load -> rsp_illegal=1.
REQ-023 rsp_ready=0 for 3 cycles after LW addr 0x0 -> rsp_valid=1, rsp_rdata=0x00000000 stable, req_ready=0 throughout; released on rsp_ready=1.
REQ-024 rst_n=0 asserted in STORE_WR of SW addr 0x4, wdata 0x12345678 -> mem_write falls without waiting for an edge, word 1 remains 0x00000002, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store at a time, performs the
// data-memory access (read-modify-write for byte/halfword stores) and holds
// the response until the consumer takes it.
module load_store_unit #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_illegal,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE_RD, STORE_WR, RESP} state_t;

    state_t      state, state_next;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        handshake;
    logic        illegal_in;
    logic        misaligned_in;
    logic        fault_in;
    logic [1:0]  lane_in;

    assign handshake = req_valid & req_ready;
    assign fault_in  = illegal_in | misaligned_in;

    // Pick the addressed byte/halfword out of a word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace the addressed byte/halfword lane of the old word with store data.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [15:0] wd,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  lane);
        logic [31:0] m;
        m = old;
        if (f3[0]) m[{lane[1], 4'b0000} +: 16] = wd;
        else       m[{lane, 3'b000} +: 8]      = wd[7:0];
        return m;
    endfunction

    // Classify the incoming request: illegal funct3, misalignment, effective lane.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        illegal_in    = 1'b0;
        misaligned_in = 1'b0;
        lane_in       = req_addr[1:0];
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal_in = 1'b0;
            3'b100, 3'b101:         illegal_in = req_we;
            default:                illegal_in = 1'b1;
        endcase
        if (ALIGN_CHECK) begin
            if (req_funct3[1:0] == 2'b01) misaligned_in = req_addr[0];
            if (req_funct3[1:0] == 2'b10) misaligned_in = |req_addr[1:0];
            // Illegal encoding wins so the two fault flags never both fire.
            if (illegal_in) misaligned_in = 1'b0;
        end else begin
            if (req_funct3[1:0] == 2'b01) lane_in = {req_addr[1], 1'b0};
            if (req_funct3[1:0] == 2'b10) lane_in = 2'b00;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (handshake) begin
                if (fault_in)                       state_next = RESP;
                else if (!req_we)                   state_next = LOAD;
                else if (req_funct3[1:0] == 2'b10)  state_next = STORE_WR;
                else                                state_next = STORE_RD;
            end
            LOAD:     state_next = RESP;
            STORE_RD: state_next = STORE_WR;
            STORE_WR: state_next = RESP;
            RESP:     if (rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output decode: strobes come straight from state so reset drops them at once.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state)
            IDLE:           req_ready = 1'b1;
            LOAD, STORE_RD: mem_read  = 1'b1;
            STORE_WR:       mem_write = 1'b1;
            RESP:           rsp_valid = 1'b1;
            default:        ;
        endcase
    end

    // Request capture, memory address/data registers and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all datapath registers are reset; there is no storage array here to exempt.
        if (!rst_n) begin
            funct3_q       <= 3'b000;
            lane_q         <= 2'b00;
            wdata_q        <= 16'h0;
            rsp_rdata      <= 32'h0;
            rsp_misaligned <= 1'b0;
            rsp_illegal    <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
        end else begin
            case (state)
                IDLE: if (handshake) begin
                    funct3_q       <= req_funct3;
                    lane_q         <= lane_in;
                    wdata_q        <= req_wdata[15:0];
                    rsp_rdata      <= 32'h0;
                    rsp_illegal    <= illegal_in;
                    rsp_misaligned <= misaligned_in;
                    if (!fault_in) begin
                        mem_address <= {req_addr[31:2], 2'b00};
                        // Full-word stores skip the read, so their data is ready now.
                        if (req_we && req_funct3[1:0] == 2'b10) mem_write_data <= req_wdata;
                    end
                end
                LOAD:     rsp_rdata      <= extract(mem_read_data, funct3_q, lane_q);
                STORE_RD: mem_write_data <= merge(mem_read_data, wdata_q, funct3_q, lane_q);
                default:  ;
            endcase
        end
    end

endmodule
